// File: rtl/prog_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prog_loader: byte-stream to instruction-memory loader with XOR checksum;  |
// | keeps the core in hold until a verified image is in memory.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module prog_loader #(
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [7:0]            in_data,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH:0]   words_loaded
);

   localparam int          CW    = ADDR_WIDTH + 1;
   localparam logic [31:0] DEPTH = 32'd1 << ADDR_WIDTH;

   typedef enum logic [2:0] {
      S_COUNT = 3'd0,
      S_DATA  = 3'd1,
      S_CSUM  = 3'd2,
      S_DONE  = 3'd3,
      S_ERROR = 3'd4
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [CW-1:0]   count;
   logic [7:0]      csum_acc;
   logic [1:0]      byte_idx;
   logic [23:0]     partial;
   logic            accept;
   logic            count_bad;
   logic            last_word;

   assign accept    = in_valid && in_ready;
   assign count_bad = (32'(in_data) == 32'd0) || (32'(in_data) > DEPTH);
   // words_loaded still excludes the word whose last byte is arriving now
   assign last_word = ((words_loaded + CW'(1)) == count);

   always_ff @(posedge clk) begin
      if (reset) state <= S_COUNT;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      done       = 1'b0;
      error      = 1'b0;
      cpu_hold   = 1'b1;
      case (state)
         S_COUNT: begin
            in_ready = 1'b1;
            if (in_valid) state_next = count_bad ? S_ERROR : S_DATA;
         end
         S_DATA: begin
            in_ready = 1'b1;
            if (in_valid && (byte_idx == 2'd3) && last_word) state_next = S_CSUM;
         end
         S_CSUM: begin
            in_ready = 1'b1;
            if (in_valid) state_next = (in_data == csum_acc) ? S_DONE : S_ERROR;
         end
         S_DONE: begin
            done     = 1'b1;
            cpu_hold = 1'b0;
            if (start) state_next = S_COUNT;
         end
         S_ERROR: begin
            error = 1'b1;
            if (start) state_next = S_COUNT;
         end
         default: state_next = S_COUNT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count        <= '0;
         csum_acc     <= '0;
         byte_idx     <= '0;
         partial      <= '0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         words_loaded <= '0;
      end else begin
         mem_we <= 1'b0;
         if (accept) begin
            case (state)
               S_COUNT: begin
                  if (!count_bad) begin
                     count        <= CW'(in_data);
                     csum_acc     <= '0;
                     byte_idx     <= '0;
                     mem_addr     <= '0;
                     words_loaded <= '0;
                  end
               end
               S_DATA: begin
                  csum_acc <= csum_acc ^ in_data;
                  byte_idx <= byte_idx + 2'd1;
                  // little-endian: earlier bytes slide toward the low end
                  partial  <= {in_data, partial[23:8]};
                  if (byte_idx == 2'd3) begin
                     mem_we       <= 1'b1;
                     mem_wdata    <= {in_data, partial};
                     mem_addr     <= words_loaded[ADDR_WIDTH-1:0];
                     words_loaded <= words_loaded + CW'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// Self-checking bench for prog_loader: directed scenarios plus random images
// checked against a byte-stream reference model.
module tb_prog_loader;

   localparam int AW    = 5;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          in_valid;
   logic          in_ready;
   logic [7:0]    in_data;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          cpu_hold;
   logic          done;
   logic          error;
   logic [AW:0]   words_loaded;

   always #5 clk = ~clk;

   prog_loader #(.ADDR_WIDTH(AW)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .cpu_hold     (cpu_hold),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   typedef struct {
      int          addr;
      logic [31:0] data;
   } wr_t;

   int         total = 0;
   int         bad   = 0;
   wr_t        exp_q[$];
   wr_t        mon_e;
   logic [7:0] stream_data[$];
   bit         mon_en = 1'b0;
   int         exp_wl = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Every write the DUT issues must be the next one the model predicts.
   always @(negedge clk) begin
      if (mon_en && mem_we !== 1'b0) begin
         if (exp_q.size() == 0) begin
            check("unexpected_mem_we", {63'd0, mem_we}, 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("wr_addr", 64'(mem_addr), 64'(mon_e.addr));
            check("wr_data", 64'(mem_wdata), 64'(mon_e.data));
            check("wr_words_loaded", 64'(words_loaded), 64'(mon_e.addr + 1));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit bubbles);
      if (bubbles) begin
         in_valid = 1'b0;
         repeat ($urandom_range(1, 3)) tick();
      end
      check("in_ready_before_byte", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b1;
      in_data  = b;
      tick();
      in_valid = 1'b0;
      in_data  = 8'($urandom);
   endtask

   task automatic check_reset_values(input string tag);
      @(negedge clk);
      check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
      check({tag, "_mem_we"}, {63'd0, mem_we}, 64'd0);
      check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
      check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
      check({tag, "_cpu_hold"}, {63'd0, cpu_hold}, 64'd1);
      check({tag, "_done"}, {63'd0, done}, 64'd0);
      check({tag, "_error"}, {63'd0, error}, 64'd0);
      check({tag, "_words_loaded"}, 64'(words_loaded), 64'd0);
   endtask

   function automatic logic [7:0] xor_all();
      logic [7:0] x = 8'h00;
      foreach (stream_data[i]) x ^= stream_data[i];
      return x;
   endfunction

   task automatic fill_random(input int n);
      stream_data.delete();
      for (int i = 0; i < 4 * n; i++) stream_data.push_back(8'($urandom));
   endtask

   task automatic fill_nominal();
      stream_data = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
   endtask

   // Model: words are little-endian groups of four stream bytes at addresses
   // 0..N-1; image is good only for 1<=N<=DEPTH and a matching XOR byte.
   task automatic run_load(input int cnt, input logic [7:0] csum_byte, input bit bubbles,
                           input int start_at, input string tag);
      bit cnt_ok;
      bit good;
      cnt_ok = (cnt >= 1) && (cnt <= DEPTH);
      if (cnt_ok) begin
         for (int w = 0; w < cnt; w++) begin
            exp_q.push_back('{addr: w, data: {stream_data[4*w+3], stream_data[4*w+2],
                                               stream_data[4*w+1], stream_data[4*w]}});
         end
      end
      good = cnt_ok && (csum_byte == xor_all());
      send_byte(8'(cnt), bubbles);
      if (cnt_ok) begin
         foreach (stream_data[i]) begin
            if (i == start_at) begin
               do_start();
               check({tag, "_start_ignored_ready"}, {63'd0, in_ready}, 64'd1);
               check({tag, "_start_ignored_hold"}, {63'd0, cpu_hold}, 64'd1);
            end
            send_byte(stream_data[i], bubbles);
         end
         send_byte(csum_byte, bubbles);
         exp_wl = cnt;
      end
      @(negedge clk);
      check({tag, "_all_writes_seen"}, 64'(exp_q.size()), 64'd0);
      check({tag, "_done"}, {63'd0, done}, {63'd0, good});
      check({tag, "_error"}, {63'd0, error}, {63'd0, !good});
      check({tag, "_cpu_hold"}, {63'd0, cpu_hold}, {63'd0, !good});
      check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
      check({tag, "_words_loaded"}, 64'(words_loaded), 64'(exp_wl));
      exp_q.delete();
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (3) tick();
      reset  = 1'b0;
      mon_en = 1'b1;
      check_reset_values("reset");

      fill_nominal();
      run_load(2, 8'h71, 1'b0, -1, "nominal");

      do_start();
      @(negedge clk);
      check("restart_cpu_hold", {63'd0, cpu_hold}, 64'd1);
      check("restart_done", {63'd0, done}, 64'd0);
      check("restart_in_ready", {63'd0, in_ready}, 64'd1);

      fill_nominal();
      run_load(2, 8'h70, 1'b0, -1, "bad_csum");

      do_start();
      run_load(0, 8'h00, 1'b0, -1, "count_zero");
      do_start();
      run_load(33, 8'h00, 1'b0, -1, "count_33");

      do_start();
      fill_random(DEPTH);
      run_load(DEPTH, xor_all(), 1'b0, -1, "count_full");

      do_start();
      fill_nominal();
      run_load(2, 8'h71, 1'b1, -1, "bubbles");

      do_start();
      send_byte(8'h02, 1'b0);
      send_byte(8'h93, 1'b0);
      send_byte(8'h00, 1'b0);
      reset = 1'b1;
      tick();
      reset  = 1'b0;
      exp_wl = 0;
      check_reset_values("mid_word_reset");
      fill_nominal();
      run_load(2, 8'h71, 1'b0, -1, "after_reset");

      do_start();
      fill_nominal();
      run_load(2, 8'h71, 1'b0, 5, "start_in_data");

      for (int it = 0; it < 8; it++) begin
         int         n;
         logic [7:0] cs;
         do_start();
         n = $urandom_range(1, 8);
         fill_random(n);
         cs = xor_all();
         if ($urandom_range(0, 1) == 1) cs = cs ^ 8'($urandom_range(1, 255));
         run_load(n, cs, 1'($urandom_range(0, 1)), -1, "random");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
